// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - condition evaluation, flag storage and EX/MEM control gating
//
// Purpose:
//   Holds the architectural {N,Z,C,V} flags. Evaluates the EX instruction's condition
//   field against the stored flags and gates the write/branch requests with the result.
//   Gated requests are registered into the MEM stage. Instructions squashed by a failed
//   condition are counted in a saturating counter.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ex_valid            EX holds a real instruction
//   stall               freeze all state this cycle
//   flush               kill the EX instruction (acts as a bubble)
//   cond                4-bit condition code of the EX instruction
//   alu_flags           {N,Z,C,V} produced by the ALU for the EX instruction
//   flag_write          [1] writes N,Z  [0] writes C,V
//   pc_src_in, reg_write_in, mem_write_in   ungated control requests
//   cond_ex             combinational: condition passed and instruction is live
//   flags_q             stored {N,Z,C,V}
//   pc_src_m, reg_write_m, mem_write_m      registered gated controls
//   squash_cnt          saturating count of condition-failed instructions
module cond_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_write,
  input  logic             pc_src_in,
  input  logic             reg_write_in,
  input  logic             mem_write_in,
  output logic             cond_ex,
  output logic [3:0]       flags_q,
  output logic             pc_src_m,
  output logic             reg_write_m,
  output logic             mem_write_m,
  output logic [CNT_W-1:0] squash_cnt
);

  logic             flag_n, flag_z, flag_c, flag_v;
  logic             cond_pass;
  logic             live;
  logic [3:0]       flags_d;
  logic             pc_src_d, reg_write_d, mem_write_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Conditions look only at the stored flags; the ALU result of the current
  // instruction becomes visible to the following instruction.
  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  assign live    = ex_valid && !flush && !stall;
  assign cond_ex = live && cond_pass;

  always_comb begin
    flags_d     = flags_q;
    pc_src_d    = pc_src_m;
    reg_write_d = reg_write_m;
    mem_write_d = mem_write_m;
    cnt_d       = cnt_q;
    if (!stall) begin
      pc_src_d    = pc_src_in    && cond_ex;
      reg_write_d = reg_write_in && cond_ex;
      mem_write_d = mem_write_in && cond_ex;
      // N,Z and C,V halves are written independently.
      if (cond_ex && flag_write[1]) flags_d[3:2] = alu_flags[3:2];
      if (cond_ex && flag_write[0]) flags_d[1:0] = alu_flags[1:0];
      // Stall is already excluded here, so live && !cond_pass is a squash.
      if (live && !cond_pass && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q     <= 4'b0000;
      pc_src_m    <= 1'b0;
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      cnt_q       <= '0;
    end else begin
      flags_q     <= flags_d;
      pc_src_m    <= pc_src_d;
      reg_write_m <= reg_write_d;
      mem_write_m <= mem_write_d;
      cnt_q       <= cnt_d;
    end
  end

  assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n, ex_valid, stall, flush;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_write;
  logic       pc_src_in, reg_write_in, mem_write_in;

  logic       ce8, pc8, rw8, mw8;
  logic [3:0] fl8;
  logic [7:0] cnt8;
  logic       ce2, pc2, rw2, mw2;
  logic [3:0] fl2;
  logic [1:0] cnt2;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [3:0] m_flags = 4'b0000;
  logic       m_pc = 1'b0, m_rw = 1'b0, m_mw = 1'b0;
  int         m_cnt8 = 0, m_cnt2 = 0;

  always #5 clk = ~clk;

  cond_unit u_dut8 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .cond(cond), .alu_flags(alu_flags), .flag_write(flag_write),
    .pc_src_in(pc_src_in), .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
    .cond_ex(ce8), .flags_q(fl8), .pc_src_m(pc8), .reg_write_m(rw8),
    .mem_write_m(mw8), .squash_cnt(cnt8)
  );

  cond_unit #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .cond(cond), .alu_flags(alu_flags), .flag_write(flag_write),
    .pc_src_in(pc_src_in), .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
    .cond_ex(ce2), .flags_q(fl2), .pc_src_m(pc2), .reg_write_m(rw2),
    .mem_write_m(mw2), .squash_cnt(cnt2)
  );

  // Pairs of codes share a base predicate; the odd code is its inverse.
  function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit live, pass;
    if (!rst_n) begin
      m_flags = 4'b0000; m_pc = 0; m_rw = 0; m_mw = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (!stall) begin
      live = ex_valid && !flush;
      pass = model_pass(cond, m_flags);
      m_pc = live && pass && pc_src_in;
      m_rw = live && pass && reg_write_in;
      m_mw = live && pass && mem_write_in;
      if (live && pass) begin
        if (flag_write[1]) m_flags[3:2] = alu_flags[3:2];
        if (flag_write[0]) m_flags[1:0] = alu_flags[1:0];
      end
      if (live && !pass) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_ce;
    if (chk_en) begin
      exp_ce = ex_valid && !flush && !stall && model_pass(cond, m_flags);
      chk("cond_ex8", ce8, exp_ce);
      chk("cond_ex2", ce2, exp_ce);
      chk("flags8", fl8, m_flags);
      chk("flags2", fl2, m_flags);
      chk("ctrl8", {pc8, rw8, mw8}, {m_pc, m_rw, m_mw});
      chk("ctrl2", {pc2, rw2, mw2}, {m_pc, m_rw, m_mw});
      chk("cnt8", cnt8, m_cnt8);
      chk("cnt2", cnt2, m_cnt2);
    end
  end

  task automatic drive(input logic v, input logic s, input logic f, input logic [3:0] c,
                       input logic [3:0] a, input logic [1:0] fw,
                       input logic pc, input logic rw, input logic mw);
    ex_valid = v; stall = s; flush = f; cond = c; alu_flags = a; flag_write = fw;
    pc_src_in = pc; reg_write_in = rw; mem_write_in = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] AL = 4'b1110;

  initial begin
    // Reset with every input high.
    rst_n = 1'b0;
    drive(1, 1, 1, 4'hF, 4'hF, 2'b11, 1, 1, 1);
    tick();
    chk("rst_flags", fl8, 4'b0000);
    chk("rst_ctrl", {pc8, rw8, mw8}, 3'b000);
    chk("rst_cnt", cnt8, 8'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Failed condition: EQ with Z=0.
    drive(1, 0, 0, EQ, 4'b0100, 2'b11, 0, 0, 1);
    #1 chk("fail_cond_ex", ce8, 1'b0);
    tick();
    chk("fail_mem_write_m", mw8, 1'b0);
    chk("fail_cnt", cnt8, 8'd1);
    chk("fail_flags", fl8, 4'b0000);

    // Set then use back-to-back.
    drive(1, 0, 0, AL, 4'b0100, 2'b11, 0, 0, 0);
    tick();
    chk("set_flags", fl8, 4'b0100);
    drive(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 1, 0);
    #1 chk("use_cond_ex", ce8, 1'b1);
    tick();
    chk("use_reg_write_m", rw8, 1'b1);

    // Partial write of N,Z only.
    drive(1, 0, 0, AL, 4'b1111, 2'b11, 0, 0, 0);
    tick();
    drive(1, 0, 0, AL, 4'b0000, 2'b10, 0, 0, 0);
    tick();
    chk("partial_flags", fl8, 4'b0011);

    // Flush acts as a bubble.
    drive(1, 0, 1, AL, 4'b1010, 2'b11, 1, 1, 1);
    #1 chk("flush_cond_ex", ce8, 1'b0);
    tick();
    chk("flush_flags", fl8, 4'b0011);
    chk("flush_ctrl", {pc8, rw8, mw8}, 3'b000);

    // Every condition code against every flag value.
    for (int f = 0; f < 16; f++) begin
      drive(1, 0, 0, AL, 4'(f), 2'b11, 0, 0, 0);
      tick();
      for (int c = 0; c < 16; c++) begin
        drive(1, 0, 0, 4'(c), ~4'(f), 2'b00, c[0], c[1], c[2]);
        #1;
        if (c == 15) chk("nv_never", ce8, 1'b0);
        if (c == 14) chk("al_always", ce8, 1'b1);
        tick();
      end
    end

    // Reset mid-operation discards a pending flag write.
    rst_n = 1'b0;
    drive(1, 0, 0, AL, 4'b1111, 2'b11, 1, 1, 1);
    tick();
    chk("midrst_flags", fl8, 4'b0000);
    chk("midrst_cnt2", cnt2, 2'd0);
    rst_n = 1'b1;

    // Five failures saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 0, 0);
      tick();
    end
    chk("sat_cnt2", cnt2, 2'd3);
    chk("sat_cnt8", cnt8, 8'd5);

    drive(1, 0, 0, AL, 4'b0000, 2'b00, 0, 1, 0);
    tick();
    chk("pre_stall_rw", rw8, 1'b1);

    // Stall with a flag write pending: nothing moves.
    drive(1, 1, 0, AL, 4'b1010, 2'b11, 0, 0, 1);
    #1 chk("stall_cond_ex", ce8, 1'b0);
    tick();
    chk("stall_flags", fl8, 4'b0000);
    chk("stall_ctrl", {pc8, rw8, mw8}, 3'b010);
    chk("stall_cnt8", cnt8, 8'd5);

    // Stall and flush together with a failing condition: hold.
    drive(1, 1, 1, EQ, 4'b1111, 2'b11, 1, 0, 1);
    #1 chk("stflush_cond_ex", ce8, 1'b0);
    tick();
    chk("stflush_ctrl", {pc8, rw8, mw8}, 3'b010);
    chk("stflush_cnt8", cnt8, 8'd5);
    chk("stflush_flags", fl8, 4'b0000);

    drive(0, 0, 0, EQ, 4'b0000, 2'b00, 0, 0, 0);
    tick();
    chk("bubble_ctrl", {pc8, rw8, mw8}, 3'b000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
